// File: rtl/jpeg_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_frame_assembler
// Description : Frames a JPEG stream: JFIF header (with live quant tables
//               spliced in), FIFO-buffered entropy bytes, then the EOI marker.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_frame_assembler #(
    parameter int HEADER_LEN     = 328,
    parameter int QT_OFFSET      = 25,
    parameter int QT_COUNT       = 1,
    parameter int HDR_ADDR_WIDTH = 9,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic                      frame_end,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic [HDR_ADDR_WIDTH-1:0] hdr_raddr,
    output logic                      hdr_ren,
    input  logic [7:0]                hdr_dout,
    output logic [6:0]                qt_raddr,
    output logic                      qt_ren,
    input  logic [7:0]                qt_dout,
    output logic                      out_valid,
    output logic [7:0]                out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      overflow
);

    localparam int c_H_W   = $clog2(HEADER_LEN + 1);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [c_H_W-1:0] c_QT_LO  = c_H_W'(QT_OFFSET);
    localparam logic [c_H_W-1:0] c_QT_HI  = c_H_W'(QT_OFFSET + 64 * QT_COUNT);
    localparam logic [c_H_W-1:0] c_H_LAST = c_H_W'(HEADER_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_HDR_FETCH   = 3'd1,
        ST_HDR_PRESENT = 3'd2,
        ST_BODY        = 3'd3,
        ST_EOI_FF      = 3'd4,
        ST_EOI_D9      = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [c_H_W-1:0]   r_h;
    logic               r_sel_qt;
    logic               r_hdr_fresh;
    logic [7:0]         r_hdr_byte;
    logic               r_pending;
    logic               r_overflow;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]   r_wptr;
    logic [c_PTR_W:0]   r_rptr;

    logic               w_empty;
    logic               w_full;
    logic               w_active;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_start;
    logic               w_hdr_adv;
    logic               w_in_qt;
    logic [7:0]         w_hdr_sel;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                       (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
    assign w_active  = (r_state != ST_IDLE);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push    = in_valid && w_active && (!w_full || w_pop);
    assign w_drop    = in_valid && w_active && w_full && !w_pop;
    assign w_in_qt   = (r_h >= c_QT_LO) && (r_h < c_QT_HI);
    assign w_hdr_sel = r_sel_qt ? qt_dout : hdr_dout;

    assign busy     = w_active;
    assign overflow = r_overflow;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        hdr_ren   = 1'b0;
        hdr_raddr = '0;
        qt_ren    = 1'b0;
        qt_raddr  = '0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        w_pop     = 1'b0;
        w_start   = 1'b0;
        w_hdr_adv = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_start = 1'b1;
                    w_next  = ST_HDR_FETCH;
                end
            end
            ST_HDR_FETCH: begin
                if (w_in_qt) begin
                    qt_ren   = 1'b1;
                    qt_raddr = 7'(r_h - c_QT_LO);
                end else begin
                    hdr_ren   = 1'b1;
                    hdr_raddr = HDR_ADDR_WIDTH'(r_h);
                end
                w_next = ST_HDR_PRESENT;
            end
            ST_HDR_PRESENT: begin
                // EBR output is only guaranteed in the first cycle; later cycles use the captured copy.
                out_valid = 1'b1;
                out_data  = r_hdr_fresh ? w_hdr_sel : r_hdr_byte;
                if (out_ready) begin
                    w_hdr_adv = 1'b1;
                    w_next    = (r_h == c_H_LAST) ? ST_BODY : ST_HDR_FETCH;
                end
            end
            ST_BODY: begin
                if (!w_empty) begin
                    out_valid = 1'b1;
                    out_data  = r_mem[r_rptr[c_PTR_W-1:0]];
                    w_pop     = out_ready;
                end else if (r_pending) begin
                    w_next = ST_EOI_FF;
                end
            end
            ST_EOI_FF: begin
                out_valid = 1'b1;
                out_data  = 8'hFF;
                if (out_ready) begin
                    w_next = ST_EOI_D9;
                end
            end
            ST_EOI_D9: begin
                out_valid = 1'b1;
                out_data  = 8'hD9;
                out_last  = 1'b1;
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h         <= '0;
            r_sel_qt    <= 1'b0;
            r_hdr_fresh <= 1'b0;
            r_hdr_byte  <= 8'h00;
        end else begin
            if (w_start) begin
                r_h <= '0;
            end else if (w_hdr_adv) begin
                r_h <= r_h + 1'b1;
            end
            r_hdr_fresh <= (r_state == ST_HDR_FETCH);
            if (r_state == ST_HDR_FETCH) begin
                r_sel_qt <= w_in_qt;
            end
            if ((r_state == ST_HDR_PRESENT) && r_hdr_fresh) begin
                r_hdr_byte <= w_hdr_sel;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (w_start) begin
            r_pending <= 1'b0;
        end else if ((r_state == ST_EOI_D9) && out_ready) begin
            r_pending <= 1'b0;
        end else if (frame_end && w_active) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_start) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[c_PTR_W-1:0]] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_jpeg_frame_assembler
// Description : Scoreboard bench for jpeg_frame_assembler (QT_COUNT 1 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_frame_assembler;

    localparam int HEADER_LEN = 328;
    localparam int FIFO_DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic [8:0] hdr_raddr1, hdr_raddr2;
    logic       hdr_ren1, hdr_ren2;
    logic [7:0] hdr_dout1 = 8'h00, hdr_dout2 = 8'h00;
    logic [6:0] qt_raddr1, qt_raddr2;
    logic       qt_ren1, qt_ren2;
    logic [7:0] qt_dout1 = 8'h00, qt_dout2 = 8'h00;
    logic       out_valid1, out_valid2, out_last1, out_last2;
    logic [7:0] out_data1, out_data2;
    logic       busy1, busy2, overflow1, overflow2;

    jpeg_frame_assembler u_dut (
        .clock(clock), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
        .in_valid(in_valid), .in_data(in_data),
        .hdr_raddr(hdr_raddr1), .hdr_ren(hdr_ren1), .hdr_dout(hdr_dout1),
        .qt_raddr(qt_raddr1), .qt_ren(qt_ren1), .qt_dout(qt_dout1),
        .out_valid(out_valid1), .out_data(out_data1), .out_last(out_last1),
        .out_ready(out_ready), .busy(busy1), .overflow(overflow1)
    );

    jpeg_frame_assembler #(.QT_COUNT(2)) u_dut_qt2 (
        .clock(clock), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
        .in_valid(in_valid), .in_data(in_data),
        .hdr_raddr(hdr_raddr2), .hdr_ren(hdr_ren2), .hdr_dout(hdr_dout2),
        .qt_raddr(qt_raddr2), .qt_ren(qt_ren2), .qt_dout(qt_dout2),
        .out_valid(out_valid2), .out_data(out_data2), .out_last(out_last2),
        .out_ready(out_ready), .busy(busy2), .overflow(overflow2)
    );

    always #5 clock = ~clock;

    // EBR models: header = addr & 0xFF; quant table constant 0x01 (1 table) or addr ^ 0xA5 (2 tables)
    always @(posedge clock) begin
        if (hdr_ren1) hdr_dout1 <= hdr_raddr1[7:0];
        if (qt_ren1)  qt_dout1  <= 8'h01;
        if (hdr_ren2) hdr_dout2 <= hdr_raddr2[7:0];
        if (qt_ren2)  qt_dout2  <= {1'b0, qt_raddr2} ^ 8'hA5;
    end

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    typedef struct {
        int nbytes;
        bit rmode;
        bit stall_hdr;
        bit early_end;
        int exp_total;
        bit exp_ovf;
    } vec_t;

    exp_t q1[$];
    exp_t q2[$];
    vec_t vecs[5];

    int   checks = 0;
    int   errors = 0;
    int   rx1 = 0, rx2 = 0;
    int   hdr_viol = 0;
    bit   done1 = 0, done2 = 0;
    bit   mon_off = 0;
    bit   rmode = 0;
    bit   stall = 1;
    bit   prev_st1 = 0, prev_st2 = 0;
    logic [7:0] prev_d1 = 8'h00, prev_d2 = 8'h00;
    exp_t e1, e2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hdr_exp(input int i, input bit qt2);
        if (!qt2 && i >= 25 && i < 89) return 8'h01;
        if (qt2 && i >= 25 && i < 153) return 8'(i - 25) ^ 8'hA5;
        return 8'(i);
    endfunction

    initial forever begin
        @(posedge clock);
        #1;
        if (stall)      out_ready = 1'b0;
        else if (rmode) out_ready = 1'($urandom_range(0, 1));
        else            out_ready = 1'b1;
    end

    always @(negedge clock) begin
        if (hdr_ren2 && hdr_raddr2 >= 9'd25 && hdr_raddr2 < 9'd153) hdr_viol++;
        if (!reset && !mon_off) begin
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) chk("dut1_unexpected_byte", int'(out_data1), -1);
                else begin
                    e1 = q1.pop_front();
                    chk("dut1_data", int'(out_data1), int'(e1.d));
                    chk("dut1_last", int'(out_last1), int'(e1.l));
                end
                rx1++;
                if (out_last1) done1 = 1;
            end
            if (out_valid2 && out_ready) begin
                if (q2.size() == 0) chk("dut2_unexpected_byte", int'(out_data2), -1);
                else begin
                    e2 = q2.pop_front();
                    chk("dut2_data", int'(out_data2), int'(e2.d));
                    chk("dut2_last", int'(out_last2), int'(e2.l));
                end
                rx2++;
                if (out_last2) done2 = 1;
            end
            if (prev_st1 && out_valid1) chk("dut1_stall_hold", int'(out_data1), int'(prev_d1));
            if (prev_st2 && out_valid2) chk("dut2_stall_hold", int'(out_data2), int'(prev_d2));
        end
        prev_st1 = out_valid1 && !out_ready;
        prev_d1  = out_data1;
        prev_st2 = out_valid2 && !out_ready;
        prev_d2  = out_data2;
    end

    task automatic push_body(input logic [7:0] b);
        q1.push_back({b, 1'b0});
        q2.push_back({b, 1'b0});
    endtask

    task automatic push_eoi();
        q1.push_back({8'hFF, 1'b0});
        q1.push_back({8'hD9, 1'b1});
        q2.push_back({8'hFF, 1'b0});
        q2.push_back({8'hD9, 1'b1});
    endtask

    task automatic pulse_start();
        @(posedge clock); #1;
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
    endtask

    task automatic run_frame(input int k);
        vec_t v;
        int   c;
        int   i;
        v     = vecs[k];
        rmode = v.rmode;
        stall = v.stall_hdr;
        rx1 = 0; rx2 = 0; done1 = 0; done2 = 0;
        for (int h = 0; h < HEADER_LEN; h++) begin
            q1.push_back({hdr_exp(h, 1'b0), 1'b0});
            q2.push_back({hdr_exp(h, 1'b1), 1'b0});
        end
        pulse_start();
        chk("overflow_cleared_by_start", int'(overflow1), 0);
        if (v.stall_hdr || v.early_end) begin
            for (int b = 0; b < v.nbytes; b++) begin
                in_valid = 1'b1;
                in_data  = 8'(b);
                if (b < FIFO_DEPTH) push_body(8'(b));
                @(posedge clock); #1;
            end
            in_valid = 1'b0;
            if (v.stall_hdr) chk("overflow_set_during_header", int'(overflow1), 1);
            frame_end = 1'b1;
            @(posedge clock); #1;
            frame_end = 1'b0;
            stall     = 1'b0;
            push_eoi();
        end else begin
            c = 0;
            while (rx1 < HEADER_LEN && c < 4000) begin
                @(posedge clock);
                c++;
            end
            if (rx1 < HEADER_LEN) chk("header_timeout", rx1, HEADER_LEN);
            #1;
            i = 0;
            c = 0;
            while (i < v.nbytes && c < 4000) begin
                in_valid  = 1'b0;
                frame_end = 1'b0;
                if (HEADER_LEN + i - rx1 < 8) begin
                    in_valid = 1'b1;
                    in_data  = 8'(i);
                    push_body(8'(i));
                    if (i == v.nbytes - 1) begin
                        frame_end = 1'b1;
                        push_eoi();
                    end
                    i++;
                end
                @(posedge clock); #1;
                c++;
            end
            in_valid  = 1'b0;
            frame_end = 1'b0;
        end
        c = 0;
        while (!(done1 && done2) && c < 6000) begin
            @(posedge clock);
            c++;
        end
        if (!(done1 && done2)) chk("frame_timeout", 0, 1);
        @(negedge clock);
        chk("total_bytes_dut1", rx1, v.exp_total);
        chk("total_bytes_dut2", rx2, v.exp_total);
        chk("overflow_flag", int'(overflow1), int'(v.exp_ovf));
        chk("busy_after_eoi", int'(busy1), 0);
        chk("scoreboard_drained", q1.size() + q2.size(), 0);
        q1.delete();
        q2.delete();
    endtask

    initial begin
        //          nbytes rmode stall early total ovf
        vecs[0] = '{100, 1'b0, 1'b0, 1'b0, 430, 1'b0};
        vecs[1] = '{100, 1'b1, 1'b0, 1'b0, 430, 1'b0};
        vecs[2] = '{20,  1'b1, 1'b1, 1'b0, 346, 1'b1};
        vecs[3] = '{3,   1'b1, 1'b0, 1'b1, 333, 1'b0};
        vecs[4] = '{10,  1'b1, 1'b0, 1'b0, 340, 1'b0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_out_valid", int'(out_valid1), 0);
        chk("reset_out_last", int'(out_last1), 0);
        chk("reset_out_data", int'(out_data1), 0);
        chk("reset_busy", int'(busy1), 0);
        chk("reset_overflow", int'(overflow1), 0);
        chk("reset_hdr_ren", int'(hdr_ren1), 0);
        chk("reset_qt_ren", int'(qt_ren1), 0);
        chk("reset_hdr_raddr", int'(hdr_raddr1), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int k = 0; k < 5; k++) run_frame(k);

        // Reset in the middle of BODY: no EOI, FIFO discarded
        mon_off = 1;
        rmode   = 0;
        stall   = 0;
        pulse_start();
        repeat (2 * HEADER_LEN + 2) @(posedge clock);
        #1;
        stall = 1;
        for (int b = 0; b < 5; b++) begin
            in_valid = 1'b1;
            in_data  = 8'h30 + 8'(b);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("body_presented_before_reset", int'(out_valid1), 1);
        chk("busy_before_reset", int'(busy1), 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("reset_mid_body_out_valid", int'(out_valid1), 0);
        chk("reset_mid_body_busy", int'(busy1), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        stall = 0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("idle_input_no_output", int'(out_valid1), 0);
        end
        chk("idle_input_not_busy", int'(busy1), 0);
        q1.delete();
        q2.delete();
        mon_off = 0;

        run_frame(4);

        chk("hdr_raddr_in_qt_range", hdr_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
